// File: rtl/axis_frame_pkg.sv
// Shared defaults, counter-width helper and a default-width beat layout for the frame rebuilder.
package axis_frame_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TID_WIDTH      = 8;
  localparam int unsigned DEF_DEST_WIDTH     = 8;
  localparam int unsigned DEF_USER_PER_BYTE  = 1;
  localparam int unsigned DEF_PACKET_BEATS   = 16;
  localparam int unsigned DEF_LAST_REGEN     = 1;

  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats < 32'd1) ? 32'd1 : $clog2(beats + 32'd1);
  endfunction

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]                          data;
    logic [DEF_DATA_WIDTH/8-1:0]                        keep;
    logic [DEF_DATA_WIDTH/8-1:0]                        strb;
    logic [DEF_USER_PER_BYTE*(DEF_DATA_WIDTH/8)-1:0]    user;
    logic [DEF_TID_WIDTH-1:0]                           id;
    logic [DEF_DEST_WIDTH-1:0]                          dest;
    logic                                               last;
  } beat_default_t;

endpackage

// File: rtl/axis_frame_rebuilder_skid.sv
// Generic 2-entry register slice (output register + skid register) over a packed payload.
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic             ready_q;
  logic             accept_s, drain_s;

  // Route an accepted beat to the output register when it frees up, else park it in the skid.
  always_comb begin
    accept_s     = in_valid_i & ready_q;
    drain_s      = out_valid_q & out_ready_i;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (drain_s && skid_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain_s) begin
      out_valid_d = accept_s;
      if (accept_s) begin
        out_d = in_data_i;
      end else begin
        out_d = out_q;
      end
    end else begin
      if (accept_s) begin
        skid_d       = in_data_i;
        skid_valid_d = 1'b1;
      end else begin
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Ready is registered and only ever reflects skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= {Width{1'b0}};
      skid_q       <= {Width{1'b0}};
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = out_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/axis_frame_rebuilder.sv
// Rebuilds AXI-Stream framing (tlast, frame-constant tid/tdest) behind a skid buffer.
// Optional framing check enabled by defining AXIS_FRAME_REBUILDER_CHECK_EN; frame_done is registered.
module axis_frame_rebuilder
  import axis_frame_pkg::*;
#(
  parameter  int unsigned DataWidth        = DEF_DATA_WIDTH,
  parameter  int unsigned TidWidth         = DEF_TID_WIDTH,
  parameter  int unsigned DestWidth        = DEF_DEST_WIDTH,
  parameter  int unsigned UserWidthPerByte = DEF_USER_PER_BYTE,
  parameter  int unsigned PacketBeats      = DEF_PACKET_BEATS,
  parameter  int unsigned LastRegenerate   = DEF_LAST_REGEN,
  localparam int unsigned KeepWidth        = DataWidth / 8,
  localparam int unsigned UserWidth        = UserWidthPerByte * KeepWidth,
  localparam int unsigned CntWidth         = cnt_width(PacketBeats)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] s_axis_tdata,
  input  logic [KeepWidth-1:0] s_axis_tkeep,
  input  logic [KeepWidth-1:0] s_axis_tstrb,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [TidWidth-1:0]  s_axis_tid,
  input  logic [DestWidth-1:0] s_axis_tdest,
  input  logic [UserWidth-1:0] s_axis_tuser,
  output logic [DataWidth-1:0] m_axis_tdata,
  output logic [KeepWidth-1:0] m_axis_tkeep,
  output logic [KeepWidth-1:0] m_axis_tstrb,
  output logic [TidWidth-1:0]  m_axis_tid,
  output logic [DestWidth-1:0] m_axis_tdest,
  output logic [UserWidth-1:0] m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [CntWidth-1:0]  beat_count,
  output logic                 frame_done,
  output logic                 frame_err
);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [KeepWidth-1:0] keep;
    logic [KeepWidth-1:0] strb;
    logic [UserWidth-1:0] user;
    logic [TidWidth-1:0]  id;
    logic [DestWidth-1:0] dest;
    logic                 last;
  } beat_t;

  localparam logic [CntWidth-1:0] CntZero = CntWidth'(0);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(PacketBeats - 32'd1);
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(PacketBeats);

  beat_t                in_beat_s, out_beat_s;
  logic                 accept_s, first_s, last_s;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [TidWidth-1:0]  tid_q, tid_d;
  logic [DestWidth-1:0] dest_q, dest_d;
  logic                 frame_done_q;

  assign accept_s = s_axis_tvalid & s_axis_tready;
  assign first_s  = (cnt_q == CntZero);

  // Beat counter, last flag and first-beat capture of tid/tdest.
  always_comb begin
    last_s = 1'b0;
    cnt_d  = cnt_q;
    tid_d  = tid_q;
    dest_d = dest_q;
    if (LastRegenerate != 32'd0) begin
      last_s = (cnt_q == LastIdx);
      if (accept_s) begin
        cnt_d = last_s ? CntZero : cnt_q + CntOne;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      last_s = s_axis_tlast;
      if (!accept_s) begin
        cnt_d = cnt_q;
      end else if (s_axis_tlast) begin
        cnt_d = CntZero;
      end else if (cnt_q == MaxCnt) begin
        cnt_d = MaxCnt;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
    if (accept_s && first_s) begin
      tid_d  = s_axis_tid;
      dest_d = s_axis_tdest;
    end else begin
      tid_d  = tid_q;
      dest_d = dest_q;
    end
    in_beat_s.data = s_axis_tdata;
    in_beat_s.keep = s_axis_tkeep;
    in_beat_s.strb = s_axis_tstrb;
    in_beat_s.user = s_axis_tuser;
    in_beat_s.id   = first_s ? s_axis_tid : tid_q;
    in_beat_s.dest = first_s ? s_axis_tdest : dest_q;
    in_beat_s.last = last_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= CntZero;
      tid_q        <= {TidWidth{1'b0}};
      dest_q       <= {DestWidth{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tid_q        <= tid_d;
      dest_q       <= dest_d;
      frame_done_q <= m_axis_tvalid & m_axis_tready & out_beat_s.last;
    end
  end

  axis_skid_buffer #(
    .Width($bits(beat_t))
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (in_beat_s),
    .in_valid_i (s_axis_tvalid),
    .in_ready_o (s_axis_tready),
    .out_data_o (out_beat_s),
    .out_valid_o(m_axis_tvalid),
    .out_ready_i(m_axis_tready)
  );

`ifdef AXIS_FRAME_REBUILDER_CHECK_EN
  logic frame_err_q;

  // Early tlast, or a frame running to its full length without tlast, is a framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= (LastRegenerate == 32'd0) && accept_s &&
                     ((s_axis_tlast && (cnt_q != LastIdx)) ||
                      (!s_axis_tlast && (cnt_q == LastIdx)));
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign m_axis_tdata = out_beat_s.data;
  assign m_axis_tkeep = out_beat_s.keep;
  assign m_axis_tstrb = out_beat_s.strb;
  assign m_axis_tuser = out_beat_s.user;
  assign m_axis_tid   = out_beat_s.id;
  assign m_axis_tdest = out_beat_s.dest;
  assign m_axis_tlast = out_beat_s.last;
  assign beat_count   = cnt_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_axis_frame_rebuilder.sv
// Scoreboard bench: regenerated-last instance (PacketBeats=4) plus a forwarded-last instance.
module tb_axis_frame_rebuilder;

  localparam bit CHK_EN =
`ifdef AXIS_FRAME_REBUILDER_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic [3:0]  user;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] s_tdata, m_tdata;
  logic [3:0]  s_tkeep, s_tstrb, s_tuser, m_tkeep, m_tstrb, m_tuser;
  logic [7:0]  s_tid, s_tdest, m_tid, m_tdest;
  logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [2:0]  beat_count;
  logic        frame_done, frame_err;

  logic [31:0] s_tdata0, m_tdata0;
  logic [3:0]  s_tkeep0, m_tkeep0, m_tstrb0, m_tuser0;
  logic [7:0]  m_tid0, m_tdest0;
  logic        s_tvalid0, s_tready0, s_tlast0, m_tvalid0, m_tready0, m_tlast0;
  logic [2:0]  beat_count0;
  logic        frame_done0, frame_err0;

  axis_frame_rebuilder #(.PacketBeats(4), .LastRegenerate(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tstrb(s_tstrb),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tstrb(m_tstrb),
    .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .beat_count(beat_count), .frame_done(frame_done), .frame_err(frame_err)
  );

  axis_frame_rebuilder #(.PacketBeats(4), .LastRegenerate(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata0), .s_axis_tkeep(s_tkeep0), .s_axis_tstrb(s_tkeep0),
    .s_axis_tvalid(s_tvalid0), .s_axis_tready(s_tready0), .s_axis_tlast(s_tlast0),
    .s_axis_tid(8'h44), .s_axis_tdest(8'h55), .s_axis_tuser(4'h0),
    .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tstrb(m_tstrb0),
    .m_axis_tid(m_tid0), .m_axis_tdest(m_tdest0), .m_axis_tuser(m_tuser0),
    .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready0), .m_axis_tlast(m_tlast0),
    .beat_count(beat_count0), .frame_done(frame_done0), .frame_err(frame_err0)
  );

  int   errors = 0;
  int   checks = 0;
  int   stalls = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  int   mcnt = 0;
  logic [7:0] mid = 8'h00;
  logic [7:0] mdest = 8'h00;

  // Output-side scoreboard, frame_done expectation, stability while stalled.
  logic pend_done = 1'b0;
  logic stall_prev = 1'b0;
  exp_t snap, obs, e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_done  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      obs = {m_tdata, m_tkeep, m_tstrb, m_tuser, m_tid, m_tdest, m_tlast};
      checks++;
      if (frame_done !== pend_done) begin
        errors++;
        $display("FAIL frame_done: got %0b expected %0b at %0t", frame_done, pend_done, $time);
      end
      if (frame_done === 1'b1) done_cnt++;
      checks++;
      if (frame_err !== 1'b0) begin
        errors++;
        $display("FAIL frame_err_regen: got %0b expected 0", frame_err);
      end
      if (stall_prev) begin
        checks++;
        if (m_tvalid !== 1'b1 || obs !== snap) begin
          errors++;
          $display("FAIL stable: got valid=%0b %h expected valid=1 %h", m_tvalid, obs, snap);
        end
      end
      pend_done = 1'b0;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL beat: got %h expected %h", obs, e);
          end
          pend_done = e.last;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      snap = obs;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [7:0] tid, input logic [7:0] tdest,
                           input logic [3:0] keep, input logic [3:0] user);
    exp_t x;
    bit   acc = 1'b0;
    int   guard = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tid = tid; s_tdest = tdest;
    s_tkeep = keep; s_tstrb = keep; s_tuser = user; s_tlast = 1'b0;
    while (!acc) begin
      acc = s_tready;
      if (acc) begin
        if (mcnt == 0) begin
          mid = tid;
          mdest = tdest;
        end
        x = {d, keep, keep, user, mid, mdest, (mcnt == 3)};
        mcnt = (mcnt == 3) ? 0 : mcnt + 1;
        exp_q.push_back(x);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got no s_tready expected accept within 50 cycles");
        acc = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tvalid0 = 1'b0; m_tready = 1'b1; m_tready0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); mcnt = 0; mid = 8'h00; mdest = 8'h00;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_tready = 1'b1; m_tready0 = 1'b1; s_tvalid0 = 1'b0;
    s_tdata0 = 32'h0; s_tkeep0 = 4'h0; s_tlast0 = 1'b0;
    s_tvalid = 1'b1; s_tdata = 32'hDEAD0001; s_tid = 8'h3C; s_tdest = 8'h7A;
    s_tkeep = 4'hF; s_tstrb = 4'hF; s_tuser = 4'h1; s_tlast = 1'b0;
    #3;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0b expected 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %0b expected 0", m_tvalid); end
    checks++; if (beat_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", beat_count); end
    checks++; if (m_tid !== 8'h00 || m_tdest !== 8'h00) begin errors++; $display("FAIL rst_id: got %h/%h expected 00/00", m_tid, m_tdest); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL release_tready: got %0b expected 0", s_tready); end
    @(posedge clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL first_edge_tready: got %0b expected 1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL pre_accept_tvalid: got %0b expected 0", m_tvalid); end
    send_beat(32'hDEAD0001, 8'h3C, 8'h7A, 4'hF, 4'h1);
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL latency: got tvalid %0b expected 1", m_tvalid); end
    checks++; if (beat_count !== 3'd1) begin errors++; $display("FAIL count_after_first: got %0d expected 1", beat_count); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_continuous();
    int d0, s0;
    do_reset();
    d0 = done_cnt; s0 = stalls;
    for (int i = 0; i < 12; i++) send_beat(32'h100 + i, 8'h11, 8'h22, 4'(i), 4'(i + 3));
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stalls - s0 !== 0) begin errors++; $display("FAIL throughput: got %0d stalls expected 0", stalls - s0); end
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL frame_count: got %0d expected 3", done_cnt - d0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL cont_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(32'hA000 + i, 8'h21, 8'h31, 4'hF, 4'(i));
        s_tvalid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        m_tready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_tready: got %0b expected 0", s_tready); end
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid: got %0b expected 1", m_tvalid); end
        checks++; if (exp_q.size() !== 2) begin errors++; $display("FAIL bp_buffered: got %0d expected 2", exp_q.size()); end
        m_tready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size()); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_recover: got %0b expected 1", s_tready); end
  endtask

  task automatic test_tid_hold();
    do_reset();
    send_beat(32'hB0, 8'h05, 8'h60, 4'hF, 4'h0);
    for (int i = 1; i < 8; i++) send_beat(32'hB0 + i, 8'h09, 8'h61, 4'hF, 4'h0);
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL tid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_last_forward();
    bit exp_last;
    do_reset();
    checks++; if (s_tready0 !== 1'b1) begin errors++; $display("FAIL fwd_ready: got %0b expected 1", s_tready0); end
    for (int i = 0; i < 3; i++) begin
      exp_last = (i == 2);
      s_tvalid0 = 1'b1; s_tdata0 = 32'hC0 + i; s_tkeep0 = 4'hF; s_tlast0 = exp_last;
      @(posedge clk); #1;
      checks++;
      if (m_tvalid0 !== 1'b1 || m_tdata0 !== 32'hC0 + i || m_tlast0 !== exp_last) begin
        errors++;
        $display("FAIL fwd_beat%0d: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                 i, m_tvalid0, m_tdata0, m_tlast0, 32'hC0 + i, exp_last);
      end
      checks++;
      if (beat_count0 !== (exp_last ? 3'd0 : 3'(i + 1))) begin
        errors++;
        $display("FAIL fwd_count%0d: got %0d expected %0d", i, beat_count0, exp_last ? 0 : i + 1);
      end
      checks++;
      if (frame_err0 !== (exp_last & CHK_EN)) begin
        errors++;
        $display("FAIL fwd_err%0d: got %0b expected %0b", i, frame_err0, exp_last & CHK_EN);
      end
    end
    s_tvalid0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (frame_err0 !== 1'b0) begin errors++; $display("FAIL fwd_err_pulse: got %0b expected 0", frame_err0); end
  endtask

  task automatic test_reset_midframe();
    int d0;
    do_reset();
    send_beat(32'hD0, 8'h71, 8'h72, 4'hF, 4'h0);
    send_beat(32'hD1, 8'h71, 8'h72, 4'hF, 4'h0);
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre: got %0b expected 1", m_tvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_async: got %0b expected 0", m_tvalid); end
    checks++; if (beat_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", beat_count); end
    exp_q.delete(); mcnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) send_beat(32'hE0 + i, 8'h81, 8'h82, 4'h3, 4'h2);
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL mid_frames: got %0d expected 1", done_cnt - d0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_backpressure();
    test_tid_hold();
    test_last_forward();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
